// File: rtl/ifft_pkg.sv
// Shared constants, state encoding and helpers for the 16-point streaming IFFT.
// Twiddles are stored pre-conjugated so the butterfly never negates an imaginary part.
package ifft_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMPUTE,
        ST_UNLOAD
    } state_t;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // W^(-k) for k = 0..7 in Q8.8, packed {re, im}
    function automatic logic [2*DATA_W-1:0] twiddle(input logic [2:0] k);
        logic [2*DATA_W-1:0] w;
        case (k)
            3'd0:    w = 32'h0100_0000;
            3'd1:    w = 32'h00ED_0062;
            3'd2:    w = 32'h00B5_00B5;
            3'd3:    w = 32'h0062_00ED;
            3'd4:    w = 32'h0000_0100;
            3'd5:    w = 32'hFF9E_00ED;
            3'd6:    w = 32'hFF4B_00B5;
            default: w = 32'hFF13_0062;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 DIT butterfly: t = b*w, y0 = (a+t)/2, y1 = (a-t)/2.
// All operands Q8.8 packed {re, im}; results truncate without saturation.
module ifft_butterfly
    import ifft_pkg::*;
#(
    parameter int DW = DATA_W
) (
    input  logic [2*DW-1:0] a,
    input  logic [2*DW-1:0] b,
    input  logic [2*DW-1:0] w,
    output logic [2*DW-1:0] y0,
    output logic [2*DW-1:0] y1
);

    logic signed [DW-1:0]   a_re, a_im, b_re, b_im, w_re, w_im;
    logic signed [2*DW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [2*DW:0]   s_re, s_im;
    logic signed [DW-1:0]   t_re, t_im;
    logic signed [DW:0]     sum_re, sum_im, dif_re, dif_im;

    assign a_re = a[2*DW-1:DW];
    assign a_im = a[DW-1:0];
    assign b_re = b[2*DW-1:DW];
    assign b_im = b[DW-1:0];
    assign w_re = w[2*DW-1:DW];
    assign w_im = w[DW-1:0];

    assign p_rr = b_re * w_re;
    assign p_ii = b_im * w_im;
    assign p_ri = b_re * w_im;
    assign p_ir = b_im * w_re;

    // One guard bit on the sums so the Q16.16 -> Q8.8 rescale never wraps early
    assign s_re = (2*DW+1)'(p_rr) - (2*DW+1)'(p_ii);
    assign s_im = (2*DW+1)'(p_ri) + (2*DW+1)'(p_ir);
    assign t_re = DW'(s_re >>> FRAC_W);
    assign t_im = DW'(s_im >>> FRAC_W);

    assign sum_re = (DW+1)'(a_re) + (DW+1)'(t_re);
    assign sum_im = (DW+1)'(a_im) + (DW+1)'(t_im);
    assign dif_re = (DW+1)'(a_re) - (DW+1)'(t_re);
    assign dif_im = (DW+1)'(a_im) - (DW+1)'(t_im);

    assign y0 = {DW'(sum_re >>> 1), DW'(sum_im >>> 1)};
    assign y1 = {DW'(dif_re >>> 1), DW'(dif_im >>> 1)};

endmodule

// File: rtl/ifft_stream.sv
// Streaming 16-point IFFT: bit-reversed load, 32-cycle in-place DIT compute,
// natural-order unload with valid/ready backpressure.
module ifft_stream
    import ifft_pkg::*;
#(
    parameter int N  = 16,
    parameter int DW = DATA_W
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [2*DW-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [2*DW-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    state_t          state_reg, state_next;
    logic [AW-1:0]   load_cnt_reg;
    logic [AW:0]     bfly_cnt_reg;
    logic [AW-1:0]   out_idx_reg;
    logic [2*DW-1:0] out_data_reg;
    logic            out_valid_reg;
    logic            out_last_reg;

    logic [2*DW-1:0] buf_mem [N];

    logic            in_fire, out_fire;
    logic [1:0]      stage;
    logic [2:0]      bfly_idx;
    logic [3:0]      bfly_ext;
    logic [3:0]      top_addr_stage [4];
    logic [2:0]      tw_k_stage [4];
    logic [AW-1:0]   top_addr, bot_addr;
    logic [AW-1:0]   next_idx;
    logic [2*DW-1:0] bf_a, bf_b, bf_w, bf_y0, bf_y1;

    assign in_ready  = (state_reg == ST_LOAD);
    assign busy      = (state_reg == ST_COMPUTE) || (state_reg == ST_UNLOAD);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_reg && out_ready;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;

    assign stage    = bfly_cnt_reg[4:3];
    assign bfly_idx = bfly_cnt_reg[2:0];
    assign bfly_ext = {1'b0, bfly_idx};

    // Top address inserts a 0 at bit position s of the butterfly index;
    // the twiddle exponent is the in-group offset scaled by 8>>s.
    for (genvar gi = 0; gi < 4; gi++) begin : g_stage
        localparam logic [3:0] LOW_MASK = 4'((1 << gi) - 1);
        assign top_addr_stage[gi] = (bfly_ext & LOW_MASK) | ((bfly_ext & ~LOW_MASK) << 1);
        assign tw_k_stage[gi]     = 3'((bfly_ext & LOW_MASK) << (3 - gi));
    end

    assign top_addr = top_addr_stage[stage];
    assign bot_addr = top_addr | (AW'(1) << stage);
    assign bf_a     = buf_mem[top_addr];
    assign bf_b     = buf_mem[bot_addr];
    assign bf_w     = twiddle(tw_k_stage[stage]);
    assign next_idx = out_idx_reg + 1'b1;

    ifft_butterfly #(.DW(DW)) u_butterfly (
        .a  (bf_a),
        .b  (bf_b),
        .w  (bf_w),
        .y0 (bf_y0),
        .y1 (bf_y1)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD:    if (in_fire && load_cnt_reg == LAST_IDX) state_next = ST_COMPUTE;
            ST_COMPUTE: if (bfly_cnt_reg == '1)                  state_next = ST_UNLOAD;
            ST_UNLOAD:  if (out_fire && out_last_reg)            state_next = ST_LOAD;
            default:    state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg     <= ST_LOAD;
            load_cnt_reg  <= '0;
            bfly_cnt_reg  <= '0;
            out_idx_reg   <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (in_fire)
                load_cnt_reg <= load_cnt_reg + 1'b1;
            if (state_reg == ST_COMPUTE)
                bfly_cnt_reg <= bfly_cnt_reg + 1'b1;
            // Output register fills one cycle after entering UNLOAD, then
            // only moves on a handshake so data/last hold under backpressure
            if (state_reg == ST_UNLOAD) begin
                if (!out_valid_reg) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= buf_mem[out_idx_reg];
                    out_last_reg  <= (out_idx_reg == LAST_IDX);
                end else if (out_ready) begin
                    if (out_last_reg) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        out_idx_reg   <= '0;
                    end else begin
                        out_idx_reg  <= next_idx;
                        out_data_reg <= buf_mem[next_idx];
                        out_last_reg <= (next_idx == LAST_IDX);
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (in_fire)
            buf_mem[bitrev4(load_cnt_reg)] <= in_data;
        if (state_reg == ST_COMPUTE) begin
            buf_mem[top_addr] <= bf_y0;
            buf_mem[bot_addr] <= bf_y1;
        end
    end

endmodule

// File: tb/tb_ifft_stream.sv
// Directed bench for ifft_stream: impulse, DC, single bin, gaps, backpressure
// and mid-compute reset, all against hand-computed Q8.8 results.
module tb_ifft_stream;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] frame [16];
    logic [31:0] expv  [16];

    // Exact results for X[1]=1.0 given truncating Q8.8 arithmetic
    logic [31:0] bin1_tab [16] = '{
        32'h0010_0000, 32'h000E_0006, 32'h000B_000B, 32'h0006_000E,
        32'h0000_0010, 32'hFFF9_000E, 32'hFFF4_000B, 32'hFFF1_0006,
        32'hFFF0_0000, 32'hFFF1_FFFA, 32'hFFF5_FFF5, 32'hFFFA_FFF1,
        32'h0000_FFF0, 32'h0006_FFF1, 32'h000B_FFF5, 32'h000F_FFFA
    };

    ifft_stream #(.N(16), .DW(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_impulse();
        for (int i = 0; i < 16; i++) begin
            frame[i] = (i == 0) ? 32'h0100_0000 : 32'h0;
            expv[i]  = 32'h0010_0000;
        end
    endtask

    task automatic set_dc();
        for (int i = 0; i < 16; i++) begin
            frame[i] = 32'h0100_0000;
            expv[i]  = (i == 0) ? 32'h0100_0000 : 32'h0;
        end
    endtask

    task automatic set_bin1();
        for (int i = 0; i < 16; i++) begin
            frame[i] = (i == 1) ? 32'h0100_0000 : 32'h0;
            expv[i]  = bin1_tab[i];
        end
    endtask

    // Returns just after the edge that accepts the 16th sample
    task automatic send_frame(input bit gaps, input bit junk_after);
        int k = 0;
        int guard = 0;
        bit tog = 1'b0;
        while (k < 16 && guard < 200) begin
            @(negedge CLK);
            guard++;
            if (gaps && tog) begin
                in_valid = 1'b0;
                in_data  = 32'hDEAD_BEEF;
            end else begin
                in_valid = 1'b1;
                in_data  = frame[k];
            end
            tog = ~tog;
            if (in_valid && in_ready) k++;
        end
        check("load_accepts", k, 16);
        @(posedge CLK);
        #1;
        if (junk_after) begin
            in_valid = 1'b1;
            in_data  = 32'hDEAD_BEEF;
        end else begin
            in_valid = 1'b0;
        end
        check("in_ready_compute", in_ready, 1'b0);
        check("busy_compute", busy, 1'b1);
    endtask

    task automatic wait_first_out();
        int cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        check("latency", cyc, 33);
    endtask

    task automatic collect(input int stall_idx);
        int idx = 0;
        int stall = 0;
        int guard = 0;
        in_valid = 1'b0;
        while (idx < 16 && guard < 300) begin
            @(negedge CLK);
            guard++;
            if (out_valid && idx == stall_idx && stall < 5) begin
                out_ready = 1'b0;
                stall++;
                check("hold_data", out_data, expv[idx]);
                check("hold_last", out_last, 1'b0);
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                $display("out n=%0d data=%h last=%b", idx, out_data, out_last);
                check($sformatf("data[%0d]", idx), out_data, expv[idx]);
                check($sformatf("last[%0d]", idx), out_last, (idx == 15));
                idx++;
            end
        end
        check("out_count", idx, 16);
        @(negedge CLK);
        out_ready = 1'b0;
        check("in_ready_after", in_ready, 1'b1);
        check("out_valid_after", out_valid, 1'b0);
        check("busy_after", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_in_ready", in_ready, 1'b1);

        set_impulse();
        send_frame(1'b0, 1'b0);
        wait_first_out();
        collect(-1);

        set_dc();
        send_frame(1'b0, 1'b0);
        wait_first_out();
        collect(-1);

        // Gapped input plus junk in_valid during COMPUTE
        set_bin1();
        send_frame(1'b1, 1'b1);
        wait_first_out();
        collect(-1);

        // Backpressure holding x[7] for five cycles
        set_bin1();
        send_frame(1'b0, 1'b0);
        wait_first_out();
        collect(7);

        // Reset in the middle of COMPUTE, then a clean impulse frame
        set_dc();
        send_frame(1'b0, 1'b0);
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_busy_rel", busy, 1'b0);
        check("midrst_out_data", out_data, 32'h0);

        set_impulse();
        send_frame(1'b0, 1'b0);
        wait_first_out();
        collect(-1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
